iic_seq: RTL



---
 rtl/iic_pkg.sv | 26 ++
 rtl/iic_seq_buf.sv | 30 +++
 rtl/iic_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/iic_pkg.sv
// Shared definitions for the IIC EEPROM block sequencer: FSM states,
// controller command encodings and buffer geometry.
package iic_pkg;

    localparam int BUF_DEPTH = 16;
    localparam int BUF_AW    = 4;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_WR   = 2'b10;
    localparam logic [1:0] CMD_RD   = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_CHECK,
        ST_GAP,
        ST_FINISH
    } state_t;

    function automatic logic len_ok(input logic [4:0] l);
        return (l != 5'd0) && (l <= 5'd16);
    endfunction

endpackage

// File: rtl/iic_seq_buf.sv
// 16x8 transfer buffer: one synchronous write port, an asynchronous read
// port for the sequencer and a registered (1-cycle) host read port.
module iic_seq_buf
    import iic_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [BUF_AW-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [BUF_AW-1:0] iraddr,
    output logic [7:0]        irdata,
    input  logic [BUF_AW-1:0] hraddr,
    output logic [7:0]        hrdata
);

    logic [7:0] mem_q [BUF_DEPTH];
    logic [7:0] hrdata_q;

    // Contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        hrdata_q <= mem_q[hraddr];
    end

    assign irdata = mem_q[iraddr];
    assign hrdata = hrdata_q;

endmodule

// File: rtl/iic_seq.sv
// Block transfer sequencer: splits a 1..16 byte EEPROM read/write into
// single-byte controller commands with timeout, retry and write-cycle gap.
module iic_seq
    import iic_pkg::*;
#(
    parameter logic [6:0]  DEV_ID      = 7'h50,
    parameter logic [15:0] WR_GAP_CYC  = 16'd5000,
    parameter logic [19:0] TIMEOUT_CYC = 20'hFFFFF,
    parameter int          MAX_RETRY   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       wr,
    input  logic [7:0] base_addr,
    input  logic [4:0] len,
    input  logic       buf_we,
    input  logic [3:0] buf_waddr,
    input  logic [7:0] buf_wdata,
    input  logic [3:0] buf_raddr,
    output logic [7:0] buf_rdata,
    output logic       seq_busy,
    output logic       done,
    output logic       err,
    output logic [3:0] err_idx,
    output logic [1:0] command,
    output logic [7:0] add,
    output logic [7:0] data_out,
    output logic [6:0] dev_id,
    input  logic       busy,
    input  logic       fail,
    input  logic [7:0] data_in
);

    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [7:0]  base_q, base_d;
    logic [4:0]  len_q, len_d;
    logic [4:0]  idx_q, idx_d;
    logic [3:0]  retry_q, retry_d;
    logic        err_q, err_d;
    logic [3:0]  err_idx_q, err_idx_d;
    logic [19:0] tmo_q, tmo_d;
    logic        to_q, to_d;
    logic [15:0] gap_q, gap_d;
    logic        done_q, done_d;
    logic [7:0]  add_q, add_d;
    logic [7:0]  dout_q, dout_d;

    logic        int_we;
    logic        buf_wen;
    logic [3:0]  buf_wa;
    logic [7:0]  buf_wd;
    logic [7:0]  irdata;
    logic        fail_eff;
    logic [4:0]  idx_inc;

    // The sequencer's own read-data write always takes the port; host writes
    // only land while no transfer is running.
    assign buf_wen = int_we | (buf_we & ~seq_busy);
    assign buf_wa  = int_we ? idx_q[3:0] : buf_waddr;
    assign buf_wd  = int_we ? data_in    : buf_wdata;

    iic_seq_buf u_buf (
        .clk    (clk),
        .we     (buf_wen),
        .waddr  (buf_wa),
        .wdata  (buf_wd),
        .iraddr (idx_d[3:0]),
        .irdata (irdata),
        .hraddr (buf_raddr),
        .hrdata (buf_rdata)
    );

    assign fail_eff = fail | to_q;
    assign idx_inc  = idx_q + 5'd1;

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        base_d    = base_q;
        len_d     = len_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        tmo_d     = tmo_q;
        to_d      = to_q;
        gap_d     = 16'd0;
        done_d    = 1'b0;
        add_d     = add_q;
        dout_d    = dout_q;
        int_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len_ok(len)) begin
                        wr_d      = wr;
                        base_d    = base_addr;
                        len_d     = len;
                        idx_d     = 5'd0;
                        retry_d   = 4'd0;
                        err_d     = 1'b0;
                        err_idx_d = 4'd0;
                        state_d   = ST_ISSUE;
                    end else begin
                        done_d    = 1'b1;
                        err_d     = 1'b1;
                        err_idx_d = 4'd0;
                    end
                end
            end
            ST_ISSUE: begin
                tmo_d   = 20'd0;
                to_d    = 1'b0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tmo_q == TIMEOUT_CYC) begin
                    to_d    = 1'b1;
                    state_d = ST_CHECK;
                end else begin
                    tmo_d = tmo_q + 20'd1;
                    if (busy) state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tmo_q == TIMEOUT_CYC) begin
                    to_d    = 1'b1;
                    state_d = ST_CHECK;
                end else begin
                    tmo_d = tmo_q + 20'd1;
                    if (!busy) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (fail_eff) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 4'd1;
                        state_d = ST_ISSUE;
                    end else begin
                        err_d     = 1'b1;
                        err_idx_d = idx_q[3:0];
                        state_d   = ST_FINISH;
                    end
                end else begin
                    int_we  = ~wr_q;
                    retry_d = 4'd0;
                    idx_d   = idx_inc;
                    if (wr_q)                 state_d = ST_GAP;
                    else if (idx_inc == len_q) state_d = ST_FINISH;
                    else                      state_d = ST_ISSUE;
                end
            end
            ST_GAP: begin
                if (({1'b0, gap_q} + 17'd1) >= {1'b0, WR_GAP_CYC}) begin
                    state_d = (idx_q == len_q) ? ST_FINISH : ST_ISSUE;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_FINISH) done_d = 1'b1;

        // Address and write data are staged on entry so they are stable for
        // the whole command cycle.
        if (state_d == ST_ISSUE) begin
            add_d  = base_d + {3'b000, idx_d};
            dout_d = irdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_q      <= 1'b0;
            base_q    <= 8'd0;
            len_q     <= 5'd0;
            idx_q     <= 5'd0;
            retry_q   <= 4'd0;
            err_q     <= 1'b0;
            err_idx_q <= 4'd0;
            tmo_q     <= 20'd0;
            to_q      <= 1'b0;
            gap_q     <= 16'd0;
            done_q    <= 1'b0;
            add_q     <= 8'd0;
            dout_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            base_q    <= base_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            tmo_q     <= tmo_d;
            to_q      <= to_d;
            gap_q     <= gap_d;
            done_q    <= done_d;
            add_q     <= add_d;
            dout_q    <= dout_d;
        end
    end

    assign command  = (state_q == ST_ISSUE) ? (wr_q ? CMD_WR : CMD_RD) : CMD_NONE;
    assign seq_busy = (state_q != ST_IDLE);
    assign done     = done_q;
    assign err      = err_q;
    assign err_idx  = err_idx_q;
    assign add      = add_q;
    assign data_out = dout_q;
    assign dev_id   = DEV_ID;

endmodule
